// File: rtl/seg7_scan2.sv
// Two-digit multiplexed 7-segment driver for a 4-bit count (0..15).
// Synchronizes q, snapshots it once per frame and scans ones/tens digits.
module seg7_scan2 #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [3:0] q,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    localparam logic [0:0] SLOT_ONES = 1'b0;
    localparam logic [0:0] SLOT_TENS = 1'b1;

    logic [3:0]    q_s1_q, q_s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]    sel_q, sel_d;
    logic [3:0]    snap_q, snap_d;
    logic          frame_q, frame_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic          slot_end;
    logic          tens;
    logic [3:0]    ones;

    function automatic logic [6:0] pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        tens     = (snap_q >= 4'd10);
        ones     = tens ? (snap_q - 4'd10) : snap_q;

        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        sel_d   = slot_end ? ~sel_q : sel_q;
        // Snapshot only at the end of the tens slot so both digits of a frame agree.
        frame_d = slot_end && (sel_q == SLOT_TENS);
        snap_d  = frame_d ? q_s2_q : snap_q;

        if (sel_q == SLOT_ONES) begin
            an_d  = 2'b10;
            seg_d = pattern(ones);
        end else begin
            an_d  = 2'b01;
            seg_d = ((BLANK_LZ != 0) && !tens) ? 7'h7F : pattern({3'b000, tens});
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            q_s1_q  <= '0;
            q_s2_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= SLOT_ONES;
            snap_q  <= '0;
            frame_q <= 1'b0;
            an_q    <= 2'b11;
            seg_q   <= 7'h7F;
        end else begin
            q_s1_q  <= q;
            q_s2_q  <= q_s1_q;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
